// File: rtl/tx_lane_scheduler_if.sv
// Lane-side bundle of tx_lane_scheduler: two requester handshakes plus the GTX word output.
// master = requester/observer side, slave = the scheduler.
interface tx_lane_scheduler_if;
  logic [15:0] src0_data;
  logic        src0_valid;
  logic        src0_ready;
  logic [15:0] src1_data;
  logic        src1_valid;
  logic        src1_last;
  logic        src1_ready;
  logic [15:0] txdata;
  logic        txdata_valid;
  logic        sync_active;

  modport master (
    output src0_data, src0_valid, src1_data, src1_valid, src1_last,
    input  src0_ready, src1_ready, txdata, txdata_valid, sync_active
  );

  modport slave (
    input  src0_data, src0_valid, src1_data, src1_valid, src1_last,
    output src0_ready, src1_ready, txdata, txdata_valid, sync_active
  );
endinterface

// File: rtl/tx_lane_scheduler.sv
// Shares the 16-bit GTX TX lane between a command stream and a framed service stream,
// inserting periodic sync bursts and idle fill. Optional counters: `define TX_LANE_STATS_EN.
module tx_lane_scheduler #(
  parameter int unsigned SYNC_PERIOD = 32,
  parameter int unsigned SYNC_LEN    = 4,
  parameter logic [15:0] SYNC_WORD   = 16'h817E,
  parameter logic [15:0] IDLE_WORD   = 16'hAAAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_ready,
  tx_lane_scheduler_if.slave    lane
`ifdef TX_LANE_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           idle_cnt,
  output logic [15:0]           sync_cnt
`endif
);

  typedef enum logic [1:0] {ST_WAIT, ST_SYNC, ST_RUN} state_e;

  localparam int PW = $clog2(SYNC_PERIOD);
  localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SYNC_PERIOD - 1);
  localparam logic [SW-1:0] SYNC_LAST   = SW'(SYNC_LEN - 1);

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_period;
  logic [SW-1:0] r_sync_idx;
  logic          r_prio1, r_frame_lock;
  logic [15:0]   r_txdata;
  logic          r_txdata_valid, r_sync_active;

  logic          w_run, w_grant0, w_grant1, w_hs0, w_hs1;
  logic          w_expire, w_sync_done, w_go_sync;
  logic [15:0]   w_txdata_nxt;
  logic          w_txvalid_nxt, w_sync_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_WAIT;
    else      r_state <= w_state_nxt;
  end

  assign w_expire    = (r_period == PERIOD_LAST);
  assign w_sync_done = (r_sync_idx == SYNC_LAST);
  // A frame that is open (or opens) at expiry defers sync until its last word has gone.
  assign w_go_sync   = w_expire && ((!r_frame_lock && !(w_hs1 && !lane.src1_last)) ||
                                    (w_hs1 && lane.src1_last));

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves a latch behind.
    w_state_nxt = r_state;
    if (!tx_ready) begin
      w_state_nxt = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT: w_state_nxt = ST_SYNC;
        ST_SYNC: if (w_sync_done) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_go_sync)   w_state_nxt = ST_SYNC;
        default: w_state_nxt = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    w_run         = (r_state == ST_RUN) && tx_ready;
    w_grant0      = 1'b0;
    w_grant1      = 1'b0;
    if (w_run) begin
      if (r_frame_lock) begin
        w_grant1 = 1'b1;
      end else if (r_prio1) begin
        if (lane.src1_valid)      w_grant1 = 1'b1;
        else if (lane.src0_valid) w_grant0 = 1'b1;
      end else begin
        if (lane.src0_valid)      w_grant0 = 1'b1;
        else if (lane.src1_valid) w_grant1 = 1'b1;
      end
    end
    w_hs0 = w_grant0 && lane.src0_valid;
    w_hs1 = w_grant1 && lane.src1_valid;

    w_txdata_nxt  = IDLE_WORD;
    w_txvalid_nxt = 1'b0;
    w_sync_nxt    = 1'b0;
    if ((r_state == ST_SYNC) && tx_ready) begin
      w_txdata_nxt = SYNC_WORD;
      w_sync_nxt   = 1'b1;
    end else if (w_hs0) begin
      w_txdata_nxt  = lane.src0_data;
      w_txvalid_nxt = 1'b1;
    end else if (w_hs1) begin
      w_txdata_nxt  = lane.src1_data;
      w_txvalid_nxt = 1'b1;
    end
  end

  assign lane.src0_ready   = w_grant0;
  assign lane.src1_ready   = w_grant1;
  assign lane.txdata       = r_txdata;
  assign lane.txdata_valid = r_txdata_valid;
  assign lane.sync_active  = r_sync_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txdata       <= IDLE_WORD;
      r_txdata_valid <= 1'b0;
      r_sync_active  <= 1'b0;
      r_period       <= '0;
      r_sync_idx     <= '0;
      r_prio1        <= 1'b0;
      r_frame_lock   <= 1'b0;
    end else begin
      r_txdata       <= w_txdata_nxt;
      r_txdata_valid <= w_txvalid_nxt;
      r_sync_active  <= w_sync_nxt;

      if ((r_state == ST_SYNC) && tx_ready && !w_sync_done) r_sync_idx <= r_sync_idx + SW'(1);
      else                                                  r_sync_idx <= '0;

      // Saturates at expiry so a deferred sync fires as soon as the frame closes.
      if (!w_run)         r_period <= '0;
      else if (!w_expire) r_period <= r_period + PW'(1);

      if (!tx_ready) begin
        r_prio1      <= 1'b0;
        r_frame_lock <= 1'b0;
      end else begin
        if (w_hs0) r_prio1 <= 1'b1;
        if (w_hs1) begin
          r_frame_lock <= !lane.src1_last;
          if (lane.src1_last) r_prio1 <= 1'b0;
        end
      end
    end
  end

`ifdef TX_LANE_STATS_EN
  logic [15:0] r_idle_cnt, r_sync_cnt;
  logic        w_idle_evt, w_burst_evt;

  assign w_idle_evt  = w_run && !w_hs0 && !w_hs1;
  assign w_burst_evt = (r_state == ST_SYNC) && tx_ready && w_sync_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
      r_sync_cnt <= '0;
    end else if (stats_clr) begin
      r_idle_cnt <= '0;
      r_sync_cnt <= '0;
    end else begin
      if (w_idle_evt  && (r_idle_cnt != 16'hFFFF)) r_idle_cnt <= r_idle_cnt + 16'd1;
      if (w_burst_evt && (r_sync_cnt != 16'hFFFF)) r_sync_cnt <= r_sync_cnt + 16'd1;
    end
  end

  assign idle_cnt = r_idle_cnt;
  assign sync_cnt = r_sync_cnt;
`endif

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed self-checking bench for tx_lane_scheduler (default parameters); outputs are
// sampled on the falling edge, inputs change right after sampling.
module tb_tx_lane_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic tx_ready;
  always #5 clk = ~clk;

  tx_lane_scheduler_if lane();

`ifdef TX_LANE_STATS_EN
  logic        stats_clr;
  logic [15:0] idle_cnt, sync_cnt;
`endif

  tx_lane_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .tx_ready (tx_ready),
    .lane     (lane)
`ifdef TX_LANE_STATS_EN
    ,
    .stats_clr(stats_clr),
    .idle_cnt (idle_cnt),
    .sync_cnt (sync_cnt)
`endif
  );

  localparam logic [15:0] SYNC = 16'h817E;
  localparam logic [15:0] IDLE = 16'hAAAA;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic v, input logic s);
    chk  ({tag, "_data"},  lane.txdata,       d);
    chk_b({tag, "_valid"}, lane.txdata_valid, v);
    chk_b({tag, "_sync"},  lane.sync_active,  s);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk_b({tag, "_rdy0"}, lane.src0_ready, r0);
    chk_b({tag, "_rdy1"}, lane.src1_ready, r1);
  endtask

  logic        p2_sel [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] a_cnt, b_cnt, exp_w;

  initial begin
    rst = 1'b0;
    tx_ready = 1'b0;
    lane.src0_data = '0; lane.src0_valid = 1'b0;
    lane.src1_data = '0; lane.src1_valid = 1'b0; lane.src1_last = 1'b0;
`ifdef TX_LANE_STATS_EN
    stats_clr = 1'b0;
`endif
    a_cnt = '0;
    b_cnt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_out("reset", IDLE, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);
    rst = 1'b1;

    // WAIT: idle while tx_ready low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_out("wait", IDLE, 1'b0, 1'b0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk_out("sync_lead", IDLE, 1'b0, 1'b0);

    // SYNC burst: sources valid but blocked, exactly 4 sync words
    lane.src0_valid = 1'b1; lane.src0_data = 16'h0A00;
    lane.src1_valid = 1'b1; lane.src1_data = 16'h0B00; lane.src1_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_rdy("sync_gate", 1'b0, 1'b0);
      @(negedge clk);
      chk_out("sync_burst", SYNC, 1'b0, 1'b1);
    end

    // Both sources streaming, 3-word src1 frames: 1 src0, 3 src1 repeating
    for (int c = 0; c < 12; c++) begin
      lane.src0_valid = 1'b1; lane.src0_data = 16'h0A00 + a_cnt;
      lane.src1_valid = 1'b1; lane.src1_data = 16'h0B00 + b_cnt;
      lane.src1_last  = (b_cnt % 16'd3 == 16'd2);
      chk_rdy("arb", !p2_sel[c], p2_sel[c]);
      @(negedge clk);
      exp_w = p2_sel[c] ? (16'h0B00 + b_cnt) : (16'h0A00 + a_cnt);
      chk_out("arb", exp_w, 1'b1, 1'b0);
      if (p2_sel[c]) b_cnt = b_cnt + 16'd1;
      else           a_cnt = a_cnt + 16'd1;
    end

    // Idle fill up to period count 30
    lane.src0_valid = 1'b0;
    lane.src1_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk_out("idle_fill", IDLE, 1'b0, 1'b0);
    end

    // 5-word src1 frame straddling period expiry: never split by sync
    for (int k = 0; k < 5; k++) begin
      lane.src1_valid = 1'b1;
      lane.src1_data  = 16'h0C00 + 16'(k);
      lane.src1_last  = (k == 4);
      chk_rdy("frame_span", 1'b0, 1'b1);
      @(negedge clk);
      chk_out("frame_span", 16'h0C00 + 16'(k), 1'b1, 1'b0);
    end
    lane.src1_valid = 1'b0;
    lane.src1_last  = 1'b0;
    lane.src0_valid = 1'b1; lane.src0_data = 16'h0D00;
    for (int i = 0; i < 4; i++) begin
      chk_rdy("post_frame_sync", 1'b0, 1'b0);
      @(negedge clk);
      chk_out("post_frame_sync", SYNC, 1'b0, 1'b1);
    end
    chk_rdy("after_sync", 1'b1, 1'b0);
    @(negedge clk);
    chk_out("after_sync", 16'h0D00, 1'b1, 1'b0);

    // src1 frame stalls 2 cycles mid-frame: idle words, src0 stays blocked
    lane.src0_data  = 16'h0D01;
    lane.src1_valid = 1'b1; lane.src1_data = 16'h0E00; lane.src1_last = 1'b0;
    chk_rdy("stall_start", 1'b0, 1'b1);
    @(negedge clk);
    chk_out("stall_start", 16'h0E00, 1'b1, 1'b0);
    lane.src1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_b("stall_gap_rdy0", lane.src0_ready, 1'b0);
      @(negedge clk);
      chk_out("stall_gap", IDLE, 1'b0, 1'b0);
    end
    lane.src1_valid = 1'b1; lane.src1_data = 16'h0E01; lane.src1_last = 1'b1;
    chk_rdy("stall_end", 1'b0, 1'b1);
    @(negedge clk);
    chk_out("stall_end", 16'h0E01, 1'b1, 1'b0);
    lane.src1_valid = 1'b0; lane.src1_last = 1'b0;
    chk_rdy("stall_src0", 1'b1, 1'b0);
    @(negedge clk);
    chk_out("stall_src0", 16'h0D01, 1'b1, 1'b0);

    // tx_ready drop mid-frame: WAIT, no handshake, lock/priority cleared, sync precedes data
    lane.src0_valid = 1'b0;
    lane.src1_valid = 1'b1; lane.src1_data = 16'h0F00; lane.src1_last = 1'b0;
    chk_rdy("drop_frame", 1'b0, 1'b1);
    @(negedge clk);
    chk_out("drop_frame", 16'h0F00, 1'b1, 1'b0);
    tx_ready = 1'b0;
    lane.src1_data  = 16'h0F01;
    lane.src0_valid = 1'b1; lane.src0_data = 16'h0D02;
    chk_rdy("drop_gate", 1'b0, 1'b0);
    @(negedge clk);
    chk_out("drop_wait", IDLE, 1'b0, 1'b0);
    tx_ready = 1'b1;
    lane.src1_data = 16'h0F00;
    chk_rdy("drop_wait", 1'b0, 1'b0);
    @(negedge clk);
    chk_out("resync_lead", IDLE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_rdy("resync", 1'b0, 1'b0);
      @(negedge clk);
      chk_out("resync", SYNC, 1'b0, 1'b1);
    end
    chk_rdy("resync_first", 1'b1, 1'b0);
    @(negedge clk);
    chk_out("resync_first", 16'h0D02, 1'b1, 1'b0);
    lane.src0_valid = 1'b0;
    lane.src1_valid = 1'b0;

`ifdef TX_LANE_STATS_EN
    // Counters: clear, one burst, 10 idle cycles, 22 data words, natural second burst
    stats_clr = 1'b1;
    tx_ready  = 1'b0;
    @(negedge clk);
    chk("stats_clr_idle", idle_cnt, 16'd0);
    chk("stats_clr_sync", sync_cnt, 16'd0);
    stats_clr = 1'b0;
    tx_ready  = 1'b1;
    repeat (5) @(negedge clk);
    chk("stats_b1_sync", sync_cnt, 16'd1);
    chk("stats_b1_idle", idle_cnt, 16'd0);
    repeat (10) @(negedge clk);
    chk("stats_idle10", idle_cnt, 16'd10);
    chk("stats_idle10_sync", sync_cnt, 16'd1);
    lane.src0_valid = 1'b1; lane.src0_data = 16'h0D10;
    repeat (22) @(negedge clk);
    lane.src0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_out("stats_b2", SYNC, 1'b0, 1'b1);
    chk("stats_b2_sync", sync_cnt, 16'd2);
    chk("stats_b2_idle", idle_cnt, 16'd10);
    stats_clr = 1'b1;
    @(negedge clk);
    chk("stats_pulse_idle", idle_cnt, 16'd0);
    chk("stats_pulse_sync", sync_cnt, 16'd0);
    stats_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tx_lane_scheduler.md
Name: tx_lane_scheduler

Overview:
- Owns the 16-bit GTX transmit lane in the txusrclk2 domain.
- Shares the lane between two requesters:
  - src0: the command-data stream from the FIFO controller, single-word transfers.
  - src1: a framed service/readback stream, multi-word with a `last` marker.
- Inserts periodic sync words and fills unused cycles with idle words.
- Holds the lane in sync/idle until the transceiver reports TX reset done.

Parameters:
- SYNC_PERIOD, 32, number of RUN words between sync insertions (min 2).
- SYNC_LEN, 4, consecutive sync words emitted per insertion (min 1).
- SYNC_WORD, 16'h817E, sync pattern.
- IDLE_WORD, 16'hAAAA, filler when no source is granted.

Ports:
- clk  input  1  txusrclk2, the lane word clock.
- rst  input  1  asynchronous, active-low reset.
- tx_ready  input  1  transceiver TX reset done, level.
- src0_data  input  16  command word.
- src0_valid  input  1  src0 word available.
- src0_ready  output  1  src0 word accepted this cycle.
- src1_data  input  16  service word.
- src1_valid  input  1  src1 word available.
- src1_last  input  1  final word of the src1 frame.
- src1_ready  output  1  src1 word accepted this cycle.
- txdata  output  16  word to GTX txdata.
- txdata_valid  output  1  high when txdata carries a source word, low for sync/idle.
- sync_active  output  1  high while txdata carries SYNC_WORD.

Behaviour:
- Reset values (rst low): txdata=IDLE_WORD, txdata_valid=0, sync_active=0, both readys=0, state=WAIT, counters=0, priority=src0, frame_lock=0.
- Readys are combinational from the current state and grant. A handshake is `valid && ready`.
- The accepted word appears on txdata on the next clk edge (1-cycle latency). txdata, txdata_valid and sync_active are registered.
- WAIT:
  - Output IDLE_WORD, both readys 0.
  - tx_ready=1 -> SYNC.
- SYNC:
  - Emit SYNC_WORD for exactly SYNC_LEN cycles with sync_active=1 and txdata_valid=0.
  - Both readys 0.
  - Then go to RUN with period counter=0.
- RUN: one word is emitted per cycle.
  - Grant rules:
    - If frame_lock=1, src1 holds the grant.
    - Otherwise the priority source wins if valid, else the other source if valid.
    - If neither is valid, emit IDLE_WORD with txdata_valid=0.
  - Only the granted source's ready is 1.
  - Priority update:
    - A src0 handshake sets priority to src1.
    - A src1 handshake with last=1 sets priority to src0.
    - A src1 handshake with last=0 sets frame_lock=1.
    - A src1 handshake with last=1 clears frame_lock.
  - While frame_lock=1 and src1_valid=0, emit IDLE_WORD. src0 stays blocked (ready=0).
  - Period counter:
    - Increments every RUN cycle, whether the cycle carries data or idle.
    - When it reaches SYNC_PERIOD-1 with frame_lock=0 and no src1 non-last handshake in that cycle, the next state is SYNC.
    - If frame_lock is set at expiry, the counter saturates and SYNC is entered on the cycle after the src1 last handshake.
- tx_ready low in any state -> WAIT on the next edge.
  - frame_lock and priority are cleared.
  - An in-progress src1 frame is abandoned; the source must restart it.
  - No handshake occurs in that cycle (readys are gated by tx_ready).
- Simultaneous events:
  - Period expiry and a src1 last handshake in the same cycle: the word is sent, then SYNC.
  - tx_ready fall has precedence over everything.

Optional Feature:
- Macro: TX_LANE_STATS_EN.
- When defined:
  - Adds outputs idle_cnt[15:0] and sync_cnt[15:0], both reset to 0.
  - idle_cnt increments on every RUN cycle emitting IDLE_WORD.
  - sync_cnt increments once per completed SYNC burst.
  - Both saturate at 16'hFFFF.
  - Both are cleared synchronously by new input stats_clr.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, tx_ready=0 for 10 cycles, then 1 -> txdata=16'hAAAA throughout WAIT, then exactly 4 cycles of 16'h817E with sync_active=1, then RUN.
- src0 and src1 both continuously valid, src1 frames of 3 words -> pattern 1×src0, 3×src1, 1×src0 repeating; txdata_valid=1 every RUN cycle; each word's txdata equals the data accepted one cycle earlier.
- src1 starts a 5-word frame at RUN count 30 (SYNC_PERIOD=32) -> all 5 words sent contiguously, then 4 sync words; sync never splits the frame.
- src1 frame with valid dropping for 2 cycles mid-frame while src0 valid -> 2 IDLE_WORD cycles, src0_ready stays 0, frame resumes.
- tx_ready deasserted mid src1 frame -> WAIT next cycle, both readys 0, frame_lock clear; after tx_ready returns, SYNC burst precedes any data.
- With TX_LANE_STATS_EN: 10 idle RUN cycles and 2 sync bursts -> idle_cnt=10, sync_cnt=2 (stats_clr held low); a stats_clr pulse -> both 0 next cycle.
